// File: rtl/midi_pkg.sv
// Shared FSM state type, status-byte constants and data-length decode for midi_msg_parser.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } midi_state_e;

    localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
    localparam logic [7:0] MIDI_TUNE_REQ    = 8'hF6;
    localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
    localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;

    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len_s;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len_s = 2'd2;
            4'hC, 4'hD:                   len_s = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h2:       len_s = 2'd2;
                    4'h1, 4'h3: len_s = 2'd1;
                    default:    len_s = 2'd0;
                endcase
            end
            default: len_s = 2'd0;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/midi_timeout.sv
// Idle-abort down-counter: reloads on clear, counts down while enabled, flags expiry at zero.
module midi_timeout #(
    parameter int TIMEOUT_CYCLES = 80_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Counter saturates at zero so a deferred expiry stays pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= LOAD_VAL;
        end else if (enable && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/midi_msg_parser.sv
// Frames a MIDI byte stream into channel, system-common and real-time messages.
// Define MIDI_RUNNING_STATUS_EN to keep channel status across messages (running status).
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 80_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_error
);

    midi_state_e state_r, state_s, done_state_s;
    logic [7:0]  status_r, status_s;
    logic [6:0]  data1_r, data1_s;
    logic        run_hold_s;
    logic        is_rt_s, timed_s, timer_en_s, timer_clr_s, expired_s, timeout_s;

    logic        valid_r, valid_s, error_r, error_s;
    logic [7:0]  ostatus_r, ostatus_s;
    logic [6:0]  od1_r, od1_s, od2_r, od2_s;
    logic [1:0]  olen_r, olen_s;

    assign is_rt_s     = (byte_in >= MIDI_RT_MIN);
    assign timed_s     = (state_r == ST_WAIT_D2) ||
                         ((state_r == ST_WAIT_D1) && (status_r[7:4] == 4'hF));
    // Real-time bytes neither clear nor advance the timer.
    assign timer_clr_s = byte_valid && !is_rt_s;
    assign timer_en_s  = timed_s && !byte_valid;
    assign timeout_s   = timer_en_s && expired_s;
    assign done_state_s = run_hold_s ? ST_WAIT_D1 : ST_IDLE;

    midi_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clr_s),
        .enable (timer_en_s),
        .expired(expired_s)
    );

`ifdef MIDI_RUNNING_STATUS_EN
    logic run_valid_r, run_valid_s;
    assign run_hold_s = run_valid_r;

    // Running status is armed by channel status and dropped by any system status.
    always_comb begin
        run_valid_s = run_valid_r;
        if (byte_valid && byte_in[7] && !is_rt_s) begin
            run_valid_s = (byte_in < MIDI_SYSEX_START);
        end else begin
            run_valid_s = run_valid_r;
        end
    end

    // Running-status flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_valid_r <= 1'b0;
        end else begin
            run_valid_r <= run_valid_s;
        end
    end
`else
    assign run_hold_s = 1'b0;
`endif

    // Next-state and next-output decode for one incoming byte or a timeout.
    always_comb begin
        state_s   = state_r;
        status_s  = status_r;
        data1_s   = data1_r;
        valid_s   = 1'b0;
        error_s   = 1'b0;
        ostatus_s = ostatus_r;
        od1_s     = od1_r;
        od2_s     = od2_r;
        olen_s    = olen_r;

        if (byte_valid && is_rt_s) begin
            valid_s   = 1'b1;
            ostatus_s = byte_in;
            od1_s     = 7'h00;
            od2_s     = 7'h00;
            olen_s    = 2'd0;
        end else if (byte_valid && byte_in[7]) begin
            if (byte_in < MIDI_SYSEX_START) begin
                status_s = byte_in;
                state_s  = ST_WAIT_D1;
            end else begin
                case (byte_in)
                    MIDI_SYSEX_START: state_s = ST_SYSEX;
                    8'hF1, 8'hF2, 8'hF3: begin
                        status_s = byte_in;
                        state_s  = ST_WAIT_D1;
                    end
                    MIDI_TUNE_REQ: begin
                        valid_s   = 1'b1;
                        ostatus_s = byte_in;
                        od1_s     = 7'h00;
                        od2_s     = 7'h00;
                        olen_s    = 2'd0;
                        state_s   = ST_IDLE;
                    end
                    8'hF4, 8'hF5, MIDI_SYSEX_END: state_s = ST_IDLE;
                    default: state_s = ST_IDLE;
                endcase
            end
        end else if (byte_valid) begin
            case (state_r)
                ST_IDLE: error_s = 1'b1;
                ST_WAIT_D1: begin
                    if (midi_data_len(status_r) == 2'd1) begin
                        valid_s   = 1'b1;
                        ostatus_s = status_r;
                        od1_s     = byte_in[6:0];
                        od2_s     = 7'h00;
                        olen_s    = 2'd1;
                        state_s   = done_state_s;
                    end else if (midi_data_len(status_r) == 2'd2) begin
                        data1_s = byte_in[6:0];
                        state_s = ST_WAIT_D2;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_D2: begin
                    valid_s   = 1'b1;
                    ostatus_s = status_r;
                    od1_s     = data1_r;
                    od2_s     = byte_in[6:0];
                    olen_s    = 2'd2;
                    state_s   = done_state_s;
                end
                ST_SYSEX: state_s = ST_SYSEX;
                default:  state_s = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            error_s = 1'b1;
            state_s = done_state_s;
        end else begin
            state_s = state_r;
        end
    end

    // FSM, partial-message and registered output state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            status_r  <= 8'h00;
            data1_r   <= 7'h00;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            ostatus_r <= 8'h00;
            od1_r     <= 7'h00;
            od2_r     <= 7'h00;
            olen_r    <= 2'd0;
        end else begin
            state_r   <= state_s;
            status_r  <= status_s;
            data1_r   <= data1_s;
            valid_r   <= valid_s;
            error_r   <= error_s;
            ostatus_r <= ostatus_s;
            od1_r     <= od1_s;
            od2_r     <= od2_s;
            olen_r    <= olen_s;
        end
    end

    assign msg_valid  = valid_r;
    assign msg_error  = error_r;
    assign msg_status = ostatus_r;
    assign msg_data1  = od1_r;
    assign msg_data2  = od2_r;
    assign msg_len    = olen_r;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed vector table, timeout corners, random vs model.
module tb_midi_msg_parser;

    localparam int T = 40;
`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS_EN = 1'b1;
    localparam logic [6:0] RS_D1 = 7'h3E;
    localparam logic [6:0] RS_D2 = 7'h40;
`else
    localparam bit RS_EN = 1'b0;
    localparam logic [6:0] RS_D1 = 7'h3C;
    localparam logic [6:0] RS_D2 = 7'h64;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       msg_valid, msg_error;
    logic [7:0] msg_status;
    logic [6:0] msg_data1, msg_data2;
    logic [1:0] msg_len;

    always #5 clock = ~clock;

    midi_msg_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
        .msg_valid(msg_valid), .msg_status(msg_status), .msg_data1(msg_data1),
        .msg_data2(msg_data2), .msg_len(msg_len), .msg_error(msg_error)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: current status (-1 = none), collected data bytes, idle count.
    int         m_status;
    bit         m_sysex, m_run;
    logic [6:0] m_pend[$];
    int         m_idle;
    logic       e_valid, e_err;
    logic [7:0] e_status;
    logic [6:0] e_d1, e_d2;
    logic [1:0] e_len;

    typedef struct {
        bit         bv;
        logic [7:0] b;
        logic       ev, ee;
        logic [7:0] es;
        logic [6:0] e1, e2;
        logic [1:0] el;
    } vec_t;
    vec_t vt[$];

    function automatic void add(bit bv, logic [7:0] b, logic ev, logic ee, logic [7:0] es,
                                logic [6:0] e1, logic [6:0] e2, logic [1:0] el);
        vec_t v;
        v.bv = bv; v.b = b; v.ev = ev; v.ee = ee; v.es = es; v.e1 = e1; v.e2 = e2; v.el = el;
        vt.push_back(v);
    endfunction

    function automatic int need_bytes(int s);
        if ((s >= 8'h80 && s <= 8'hBF) || (s >= 8'hE0 && s <= 8'hEF) || s == 8'hF2) return 2;
        if ((s >= 8'hC0 && s <= 8'hDF) || s == 8'hF1 || s == 8'hF3) return 1;
        return 0;
    endfunction

    function automatic void emit(logic [7:0] s, logic [6:0] d1, logic [6:0] d2, logic [1:0] l);
        e_valid = 1'b1; e_status = s; e_d1 = d1; e_d2 = d2; e_len = l;
    endfunction

    function automatic void model_reset();
        m_status = -1; m_sysex = 1'b0; m_run = 1'b0; m_pend.delete(); m_idle = 0;
        e_valid = 1'b0; e_err = 1'b0; e_status = 8'h00; e_d1 = 7'h00; e_d2 = 7'h00; e_len = 2'd0;
    endfunction

    function automatic void model_step(bit bv, logic [7:0] b);
        bit timed;
        timed = (m_status >= 0) &&
                ((m_pend.size() == 1) || (m_status >= 8'hF0 && m_pend.size() == 0));
        e_valid = 1'b0;
        e_err = 1'b0;
        if (bv && b >= 8'hF8) begin
            emit(b, 7'h00, 7'h00, 2'd0);
        end else if (bv) begin
            m_idle = 0;
            if (b[7]) begin
                m_pend.delete(); m_sysex = 1'b0; m_run = 1'b0; m_status = -1;
                if (b < 8'hF0) begin
                    m_status = int'(b);
                    m_run = RS_EN;
                end else if (b == 8'hF0) m_sysex = 1'b1;
                else if (b == 8'hF1 || b == 8'hF2 || b == 8'hF3) m_status = int'(b);
                else if (b == 8'hF6) emit(8'hF6, 7'h00, 7'h00, 2'd0);
            end else if (m_sysex) begin
                m_idle = 0;
            end else if (m_status < 0) begin
                e_err = 1'b1;
            end else begin
                m_pend.push_back(b[6:0]);
                if (m_pend.size() == need_bytes(m_status)) begin
                    emit(8'(m_status), m_pend[0], (m_pend.size() > 1) ? m_pend[1] : 7'h00,
                         2'(m_pend.size()));
                    m_pend.delete();
                    if (!m_run) m_status = -1;
                end
            end
        end else if (timed) begin
            m_idle++;
            if (m_idle == T) begin
                e_err = 1'b1;
                m_pend.delete();
                m_idle = 0;
                if (!m_run) m_status = -1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic ev, input logic ee, input logic [7:0] es,
                           input logic [6:0] e1, input logic [6:0] e2, input logic [1:0] el);
        chk({name, ".valid"},  32'(msg_valid),  32'(ev));
        chk({name, ".error"},  32'(msg_error),  32'(ee));
        chk({name, ".status"}, 32'(msg_status), 32'(es));
        chk({name, ".data1"},  32'(msg_data1),  32'(e1));
        chk({name, ".data2"},  32'(msg_data2),  32'(e2));
        chk({name, ".len"},    32'(msg_len),    32'(el));
    endtask

    task automatic step(input bit bv, input logic [7:0] b);
        byte_valid = bv;
        byte_in = b;
        model_step(bv, b);
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(99);
        if (r < 50)      return 8'($urandom_range(8'h7F, 8'h00));
        else if (r < 75) return 8'($urandom_range(8'hEF, 8'h80));
        else if (r < 88) return 8'($urandom_range(8'hF7, 8'hF0));
        else             return 8'($urandom_range(8'hFF, 8'hF8));
    endfunction

    initial begin
        int errs, at_k, vals, gap;
        bit rbv;
        logic [7:0] rb;

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk_all("in_reset", 1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 2'd0);
        reset = 1'b0;

        // Directed vectors: inputs and expected registered outputs one cycle later.
        add(1'b1, 8'h90, 1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 2'd0);
        add(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 2'd0);
        add(1'b1, 8'h64, 1'b1, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);
`ifdef MIDI_RUNNING_STATUS_EN
        add(1'b1, 8'h3E, 1'b0, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);
        add(1'b1, 8'h40, 1'b1, 1'b0, 8'h90, 7'h3E, 7'h40, 2'd2);
`else
        add(1'b1, 8'h3E, 1'b0, 1'b1, 8'h90, 7'h3C, 7'h64, 2'd2);
        add(1'b1, 8'h40, 1'b0, 1'b1, 8'h90, 7'h3C, 7'h64, 2'd2);
`endif
        add(1'b1, 8'h90, 1'b0, 1'b0, 8'h90, RS_D1, RS_D2, 2'd2);
        add(1'b1, 8'h3C, 1'b0, 1'b0, 8'h90, RS_D1, RS_D2, 2'd2);
        add(1'b1, 8'hF8, 1'b1, 1'b0, 8'hF8, 7'h00, 7'h00, 2'd0);
        add(1'b1, 8'h64, 1'b1, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);
        add(1'b1, 8'hC5, 1'b0, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);
        add(1'b1, 8'h07, 1'b1, 1'b0, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'hF0, 1'b0, 1'b0, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'h7E, 1'b0, 1'b0, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'h01, 1'b0, 1'b0, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'hF7, 1'b0, 1'b0, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'h45, 1'b0, 1'b1, 8'hC5, 7'h07, 7'h00, 2'd1);
        add(1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 7'h00, 7'h00, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'hF6, 7'h00, 7'h00, 2'd0);
        add(1'b1, 8'hF1, 1'b0, 1'b0, 8'hF6, 7'h00, 7'h00, 2'd0);
        add(1'b1, 8'h12, 1'b1, 1'b0, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h05, 1'b0, 1'b1, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h90, 1'b0, 1'b0, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h3C, 1'b0, 1'b0, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h80, 1'b0, 1'b0, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h40, 1'b0, 1'b0, 8'hF1, 7'h12, 7'h00, 2'd1);
        add(1'b1, 8'h00, 1'b1, 1'b0, 8'h80, 7'h40, 7'h00, 2'd2);

        foreach (vt[i]) begin
            step(vt[i].bv, vt[i].b);
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ee, vt[i].es, vt[i].e1, vt[i].e2, vt[i].el);
        end

        // Timeout: exactly one error after T idle cycles, no message.
        step(1'b1, 8'h90);
        step(1'b1, 8'h3C);
        errs = 0; at_k = 0; vals = 0;
        for (int k = 1; k <= T + 3; k++) begin
            step(1'b0, 8'h00);
            if (msg_error) begin errs++; at_k = k; end
            if (msg_valid) vals++;
        end
        chk("timeout_errs", errs, 1);
        chk("timeout_cycle", at_k, T);
        chk("timeout_no_msg", vals, 0);
        step(1'b1, 8'h3C);
`ifdef MIDI_RUNNING_STATUS_EN
        chk_all("to_rs_d1", 1'b0, 1'b0, 8'h80, 7'h40, 7'h00, 2'd2);
        step(1'b1, 8'h64);
        chk_all("to_rs_msg", 1'b1, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);
`else
        chk_all("to_stray", 1'b0, 1'b1, 8'h80, 7'h40, 7'h00, 2'd2);
`endif

        // Byte arriving on the expiry cycle wins over the timeout.
        step(1'b1, 8'h90);
        step(1'b1, 8'h3C);
        errs = 0;
        for (int k = 1; k < T; k++) begin
            step(1'b0, 8'h00);
            if (msg_error) errs++;
        end
        step(1'b1, 8'h64);
        chk("bytewin_errs", errs, 0);
        chk_all("bytewin_msg", 1'b1, 1'b0, 8'h90, 7'h3C, 7'h64, 2'd2);

        // Real-time byte on the expiry cycle defers the timeout by one cycle.
        step(1'b1, 8'h90);
        step(1'b1, 8'h3C);
        errs = 0;
        for (int k = 1; k < T; k++) begin
            step(1'b0, 8'h00);
            if (msg_error) errs++;
        end
        step(1'b1, 8'hF8);
        chk("rt_pre_errs", errs, 0);
        chk_all("rt_at_expiry", 1'b1, 1'b0, 8'hF8, 7'h00, 7'h00, 2'd0);
        step(1'b0, 8'h00);
        chk_all("rt_deferred_to", 1'b0, 1'b1, 8'hF8, 7'h00, 7'h00, 2'd0);

        // Reset mid-message drops the partial data immediately.
        step(1'b1, 8'h90);
        step(1'b1, 8'h3C);
        reset = 1'b1;
        #1;
        chk_all("reset_mid", 1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 2'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b1, 8'h64);
        chk_all("post_reset_data", 1'b0, 1'b1, 8'h00, 7'h00, 7'h00, 2'd0);

        // Random byte stream with occasional long gaps, checked against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) begin
                gap = int'($urandom_range(T + 8, T - 8));
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 8'h00);
                    chk_all("rand_gap", e_valid, e_err, e_status, e_d1, e_d2, e_len);
                end
            end
            rbv = ($urandom_range(3) != 0);
            rb = rand_byte();
            step(rbv, rb);
            chk_all("rand", e_valid, e_err, e_status, e_d1, e_d2, e_len);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Frames the raw byte stream from the MIDI UART deserializer into complete MIDI channel, system-common and real-time messages. Sits directly downstream of the deserializer's `ready`/`MIDIbyte` outputs. Sequences byte collection, tracks running status and discards SysEx payloads. Hands one fully-formed message per pulse to the voice/synth control logic.

## Interface
- `TIMEOUT_CYCLES`, 80_000: idle cycles (1.6 ms at 50 MHz, about 5 byte times) after which a partial message is aborted.
- `clock`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  asynchronous, active-high reset.
- `byte_valid`  in  1  one-cycle pulse; `byte_in` holds a new byte (deserializer `ready`).
- `byte_in`  in  8  received MIDI byte (deserializer `MIDIbyte`).
- `msg_valid`  out  1  one-cycle pulse; message fields are valid.
- `msg_status`  out  8  status byte of the message.
- `msg_data1`  out  7  first data byte; 0 if unused.
- `msg_data2`  out  7  second data byte; 0 if unused.
- `msg_len`  out  2  number of data bytes (0, 1 or 2).
- `msg_error`  out  1  one-cycle pulse on a stray data byte or a timeout abort.

## Operation
- Byte classes:
  - Status: bit7 = 1.
  - Data: bit7 = 0.
  - Real-time: 0xF8–0xFF.
- Data length by status:
  - 2 data bytes: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn, 0xF2.
  - 1 data byte: 0xCn, 0xDn, 0xF1, 0xF3.
  - 0 data bytes: 0xF6 and all real-time bytes.
- FSM states: IDLE (no valid status), WAIT_D1, WAIT_D2, SYSEX.
- Real-time byte in any state: emitted immediately as a len-0 message. State, running status, partial data and timeout counter are all untouched.
- Channel status (0x80–0xEF):
  - Latches the running-status register.
  - Goes to WAIT_D1.
  - Discards any partial message silently, with no error.
- System common 0xF1/0xF2/0xF3: goes to WAIT_D1. 0xF6: emits immediately and goes to IDLE. All system common clears running status.
- 0xF0 → SYSEX. In SYSEX, data bytes and 0xF7 are discarded with no error; 0xF7 → IDLE.
  - Any other non-real-time status in SYSEX ends SysEx and is processed normally.
- 0xF4, 0xF5, or 0xF7 outside SYSEX: ignored, clear running status, → IDLE.
- WAIT_D1 + data byte:
  - len 1: emit, then → WAIT_D1 if running status is held, else IDLE.
  - len 2: store, → WAIT_D2.
- WAIT_D2 + data byte: emit, then → WAIT_D1 if running status is held, else IDLE.
- IDLE + data byte: pulse `msg_error`, drop the byte.
- Timeout:
  - Counter runs only while in WAIT_D2, or in WAIT_D1 holding a partial system-common message. It clears on every accepted non-real-time byte.
  - On reaching TIMEOUT_CYCLES-1: pulse `msg_error`, drop the partial data.
  - Next state is WAIT_D1 if running status is valid, else IDLE.

## Timing
- Reset values: all outputs 0, FSM IDLE, running status invalid, counter 0.
- Latency: `msg_valid` is asserted the cycle after the `byte_valid` that completes a message. Fields are registered and hold until the next `msg_valid`.
- `byte_valid` may be asserted every cycle; every pulse is consumed.
- At most one of `msg_valid` and `msg_error` is asserted per cycle.
- Timeout and `byte_valid` in the same cycle: the byte wins and the counter clears.
- Reset asserted mid-message: immediate return to reset values; partial data is lost.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - The running-status register is kept after a channel message completes.
  - Further data bytes form new messages with the same status.
- Not defined:
  - After each completed channel message, the FSM → IDLE.
  - The following data byte pulses `msg_error`.
  - A timeout always → IDLE.
  - The running-status register is removed.

## Structure
- Package `midi_pkg` holds:
  - the FSM state enum;
  - the status constants (0xF0, 0xF6, 0xF7, real-time threshold 0xF8);
  - function `midi_data_len(status)` returning 0–2.
- One sub-module, `midi_timeout`:
  - a parameterised down-counter with `clear`/`enable` inputs and an `expired` output;
  - width is `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- Note-on: bytes 0x90, 0x3C, 0x64 → one `msg_valid` with status 0x90, d1 0x3C, d2 0x64, len 2.
- Running status: after note-on, send 0x3E, 0x40.
  - With the macro: message 0x90/0x3E/0x40.
  - Without the macro: `msg_error` on 0x3E, then `msg_error` on 0x40, no message.
- Real-time interleave: 0x90, 0x3C, 0xF8, 0x64 → message 0xF8 len 0 first, then 0x90/0x3C/0x64.
- Program change: 0xC5, 0x07 → status 0xC5, d1 0x07, d2 0x00, len 1.
- SysEx: 0xF0, 0x7E, 0x01, 0xF7 → no `msg_valid`, no `msg_error`. A following 0x45 → `msg_error` (running status cleared).
- Timeout: 0x90, 0x3C, then TIMEOUT_CYCLES idle cycles → one `msg_error`, no message. With the macro, a following 0x3C, 0x64 → message 0x90/0x3C/0x64.
